// File: rtl/mul_pkg.sv
// Shared types and limits for the pipelined multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_pkg;

  // Deepest pipeline the multiplier supports.
  localparam int MaxStages = 8;

  // Per-transaction mode, captured together with the operands.
  typedef struct packed {
    logic is_signed;  // 1 = operands are two's complement
    logic high;       // 1 = return upper half of the product
  } mul_mode_t;

endpackage

// File: rtl/mul_pipe_stage.sv
// One valid/data pipeline register with valid-ready handshake and flush.
// Latency: 1 cycle. Ports: in_valid/in_ready/in_data, out_valid/out_ready/out_data, flush.
// Backpressure: holds its contents while out_ready_i is low; accepts when empty or draining.
module mul_pipe_stage #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  // Free slot, or the current occupant leaves this cycle.
  assign in_ready_o = ~valid_q | out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
    // Flush only drops the valid bit; stale data is harmless.
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/pipelined_mul.sv
// Pipelined signed/unsigned multiplier joining two operand streams, with flush and occupancy.
// Latency: NumStages cycles from accept to result_valid_o; throughput 1/cycle.
// Backpressure: full valid-ready; stalls collapse bubbles, ready drops only when stage 0 cannot move.
// Ports: a/b operand streams (joined), signed_i/high_i mode, clear_i flush,
//        result stream out, occupancy_o = in-flight operation count.
module pipelined_mul
  import mul_pkg::*;
#(
  parameter  int DataWidth = 64,
  parameter  int NumStages = 3,
  localparam int OccWidth  = $clog2(NumStages + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] a_i,
  input  logic                 a_valid_i,
  output logic                 a_ready_o,
  input  logic [DataWidth-1:0] b_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic                 signed_i,
  input  logic                 high_i,
  input  logic                 clear_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [OccWidth-1:0]  occupancy_o
);

  if (NumStages < 1 || NumStages > MaxStages) begin : g_bad_stages
    $error("pipelined_mul: NumStages out of range");
  end

  // Inner stages carry {high, full product}; the last stage holds only the chosen half.
  localparam int PayW = 2 * DataWidth + 1;

  // Extend both operands to 2W (sign or zero) and multiply mod 2^(2W).
  function automatic logic [2*DataWidth-1:0] ext_mul(input logic [DataWidth-1:0] a,
                                                     input logic [DataWidth-1:0] b,
                                                     input logic             sgn);
    logic [2*DataWidth-1:0] ea, eb;
    ea = {{DataWidth{sgn & a[DataWidth-1]}}, a};
    eb = {{DataWidth{sgn & b[DataWidth-1]}}, b};
    return ea * eb;
  endfunction

  mul_mode_t            mode;
  logic                 in_vld, accept, pop;
  logic [NumStages-1:0] vld, rdy, stg_in_vld, stg_out_rdy;
  logic [PayW-1:0]      stage_in [NumStages];
  logic [DataWidth-1:0] last_in;
  logic [OccWidth-1:0]  occ_q, occ_d;

  assign mode = '{is_signed: signed_i, high: high_i};

  // Join: both operands present, no flush, not in reset, stage 0 can take it.
  assign in_vld    = a_valid_i & b_valid_i & ~clear_i & ~rst_i;
  assign accept    = in_vld & rdy[0];
  assign a_ready_o = accept;
  assign b_ready_o = accept;

  assign stage_in[0] = {mode.high, ext_mul(a_i, b_i, mode.is_signed)};

  // Half-select sits in front of the last register so result_o comes straight from a flop.
  assign last_in = stage_in[NumStages-1][PayW-1]
                 ? stage_in[NumStages-1][2*DataWidth-1:DataWidth]
                 : stage_in[NumStages-1][DataWidth-1:0];

  for (genvar k = 0; k < NumStages; k++) begin : g_stage
    if (k == 0) begin : g_src_in
      assign stg_in_vld[k] = in_vld;
    end else begin : g_src_prev
      assign stg_in_vld[k] = vld[k-1];
    end

    if (k == NumStages - 1) begin : g_last
      assign stg_out_rdy[k] = result_ready_i;
      mul_pipe_stage #(.Width(DataWidth)) u_stage (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (clear_i),
        .in_valid_i (stg_in_vld[k]),
        .in_ready_o (rdy[k]),
        .in_data_i  (last_in),
        .out_valid_o(vld[k]),
        .out_ready_i(stg_out_rdy[k]),
        .out_data_o (result_o)
      );
    end else begin : g_mid
      assign stg_out_rdy[k] = rdy[k+1];
      mul_pipe_stage #(.Width(PayW)) u_stage (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (clear_i),
        .in_valid_i (stg_in_vld[k]),
        .in_ready_o (rdy[k]),
        .in_data_i  (stage_in[k]),
        .out_valid_o(vld[k]),
        .out_ready_i(stg_out_rdy[k]),
        .out_data_o (stage_in[k+1])
      );
    end
  end

  assign result_valid_o = vld[NumStages-1];
  assign pop            = vld[NumStages-1] & result_ready_i;

  // Occupancy tracks set valid bits: +1 on accept, -1 on pop, zero on flush.
  always_comb begin
    occ_d = occ_q;
    if (clear_i) begin
      occ_d = '0;
    end else if (accept && !pop) begin
      occ_d = occ_q + OccWidth'(1);
    end else if (pop && !accept) begin
      occ_d = occ_q - OccWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

endmodule
